// File: rtl/ctrl_frame_capture_if.sv
// Bus bundle for the frame capture block: picosoc iomem read port plus the cfg status/config word.
interface ctrl_frame_capture_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_rdata;
  logic [3:0]  cfg_we;
  logic [31:0] cfg_di;
  logic [31:0] cfg_do;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, cfg_we, cfg_di,
    input  iomem_ready, iomem_rdata, cfg_do
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, cfg_we, cfg_di,
    output iomem_ready, iomem_rdata, cfg_do
  );
endinterface

// File: rtl/ctrl_frame_capture.sv
// Pulls one control frame at a time from PHY-RX FIFOs 0-3 into a 64 B buffer read by picosoc;
// frames arriving while the CPU still owns the buffer are drained and counted, never stalled.
module ctrl_frame_capture #(
  parameter int BUF_WORDS = 16,
  parameter int DROP_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] p0_fifo_dout,
  input  logic       p0_fifo_del,
  input  logic       p0_fifo_empty,
  output logic       p0_fifo_rden,
  input  logic [7:0] p1_fifo_dout,
  input  logic       p1_fifo_del,
  input  logic       p1_fifo_empty,
  output logic       p1_fifo_rden,
  input  logic [7:0] p2_fifo_dout,
  input  logic       p2_fifo_del,
  input  logic       p2_fifo_empty,
  output logic       p2_fifo_rden,
  input  logic [7:0] p3_fifo_dout,
  input  logic       p3_fifo_del,
  input  logic       p3_fifo_empty,
  output logic       p3_fifo_rden,
  ctrl_frame_capture_if.slave bus
);

  localparam int BUF_BYTES = BUF_WORDS * 4;
  localparam int WADDR_W   = $clog2(BUF_WORDS);
  localparam int LEN_W     = $clog2(BUF_BYTES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [31:0]       buffer [BUF_WORDS];
  logic [LEN_W-1:0]  cnt;
  logic              ovf_cur;
  logic [1:0]        grant;
  logic [1:0]        rr_ptr;
  logic              frame_valid;
  logic              overflow;
  logic              enable;
  logic [3:0]        src_port;
  logic [LEN_W-1:0]  rx_len;
  logic [DROP_W-1:0] drop_cnt;
  logic [3:0]        port_mask;

  logic [7:0] dout  [4];
  logic [3:0] del;
  logic [3:0] empty;
  logic [3:0] rden;
  logic [3:0] cand;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       pop;
  logic       unused_bits;

  assign dout[0] = p0_fifo_dout;
  assign dout[1] = p1_fifo_dout;
  assign dout[2] = p2_fifo_dout;
  assign dout[3] = p3_fifo_dout;
  assign del     = {p3_fifo_del, p2_fifo_del, p1_fifo_del, p0_fifo_del};
  assign empty   = {p3_fifo_empty, p2_fifo_empty, p1_fifo_empty, p0_fifo_empty};

  assign p0_fifo_rden = rden[0];
  assign p1_fifo_rden = rden[1];
  assign p2_fifo_rden = rden[2];
  assign p3_fifo_rden = rden[3];

  assign cand = port_mask & ~empty;
  assign pop  = ~empty[grant];

  assign unused_bits = ^{bus.iomem_wstrb, bus.iomem_addr[31:WADDR_W+2], bus.iomem_addr[1:0],
                         bus.cfg_we[2:1], bus.cfg_di[30:29], bus.cfg_di[27:4]};

  // Round-robin: scan from rr_ptr upward; iterating backwards lets the nearest candidate win.
  always_comb begin
    pick = rr_ptr;
    idx  = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (cand[idx]) pick = idx;
    end
  end

  always_comb begin
    next_state = state;
    rden       = '0;
    case (state)
      S_IDLE: begin
        if (|cand) next_state = (enable && !frame_valid) ? S_RX : S_DRAIN;
      end
      S_RX: begin
        rden[grant] = pop;
        if (pop && del[grant]) next_state = S_DONE;
      end
      S_DRAIN: begin
        rden[grant] = pop;
        if (pop && del[grant]) next_state = S_IDLE;
      end
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (rst) rden = '0;
  end

  always_comb begin
    bus.cfg_do = {frame_valid, (state != S_IDLE), overflow, enable, src_port, 1'b0,
                  7'(rx_len), 8'(drop_cnt), 4'b0000, port_mask};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      ovf_cur         <= 1'b0;
      grant           <= '0;
      rr_ptr          <= '0;
      frame_valid     <= 1'b0;
      overflow        <= 1'b0;
      enable          <= 1'b0;
      src_port        <= '0;
      rx_len          <= '0;
      drop_cnt        <= '0;
      port_mask       <= '0;
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
      for (int w = 0; w < BUF_WORDS; w++) buffer[w] <= '0;
    end else begin
      state <= next_state;

      bus.iomem_ready <= bus.iomem_valid && !bus.iomem_ready;
      if (bus.iomem_valid && !bus.iomem_ready)
        bus.iomem_rdata <= buffer[bus.iomem_addr[WADDR_W+1:2]];

      case (state)
        S_IDLE: begin
          if (|cand) begin
            grant   <= pick;
            rr_ptr  <= pick + 2'd1;
            cnt     <= '0;
            ovf_cur <= 1'b0;
          end
        end
        S_RX: begin
          // Byte 0 lands in the top lane, matching the TX buffer packing.
          if (pop) begin
            if (cnt < LEN_W'(BUF_BYTES)) begin
              buffer[cnt[LEN_W-2:2]][{~cnt[1:0], 3'b000} +: 8] <= dout[grant];
              cnt <= cnt + 1'b1;
            end else begin
              ovf_cur <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (pop && del[grant] && drop_cnt != {DROP_W{1'b1}})
            drop_cnt <= drop_cnt + 1'b1;
        end
        S_DONE: begin
          frame_valid <= 1'b1;
          rx_len      <= cnt;
          src_port    <= 4'b0001 << grant;
          overflow    <= ovf_cur;
        end
        default: ;
      endcase

      if (bus.cfg_we[3]) begin
        enable <= bus.cfg_di[28];
        if (bus.cfg_di[31]) begin
          frame_valid <= 1'b0;
          overflow    <= 1'b0;
          rx_len      <= '0;
          src_port    <= '0;
        end
      end
      if (bus.cfg_we[0]) port_mask <= bus.cfg_di[3:0];
    end
  end

endmodule

// File: tb/tb_ctrl_frame_capture.sv
// Directed bench for ctrl_frame_capture: queue-based RX FIFO models feed the DUT, the bus
// bundle is driven from one initial block and each check is an immediate assertion.
module tb_ctrl_frame_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dout  [4];
  logic       del   [4];
  logic       empty [4];
  wire  [3:0] rden;

  logic [8:0] fq [4][$];
  int         pops [4];
  logic       in_frame [4];
  int         order [$];
  int         spurious;
  int         compared;
  int         mismatched;

  ctrl_frame_capture_if bus ();

  always #5 clk = ~clk;

  ctrl_frame_capture dut (
    .clk           (clk),
    .rst           (rst),
    .p0_fifo_dout  (dout[0]),
    .p0_fifo_del   (del[0]),
    .p0_fifo_empty (empty[0]),
    .p0_fifo_rden  (rden[0]),
    .p1_fifo_dout  (dout[1]),
    .p1_fifo_del   (del[1]),
    .p1_fifo_empty (empty[1]),
    .p1_fifo_rden  (rden[1]),
    .p2_fifo_dout  (dout[2]),
    .p2_fifo_del   (del[2]),
    .p2_fifo_empty (empty[2]),
    .p2_fifo_rden  (rden[2]),
    .p3_fifo_dout  (dout[3]),
    .p3_fifo_del   (del[3]),
    .p3_fifo_empty (empty[3]),
    .p3_fifo_rden  (rden[3]),
    .bus           (bus.slave)
  );

  task automatic refresh();
    for (int p = 0; p < 4; p++) begin
      empty[p] = (fq[p].size() == 0);
      dout[p]  = empty[p] ? 8'h00 : fq[p][0][7:0];
      del[p]   = empty[p] ? 1'b0  : fq[p][0][8];
    end
  endtask

  // FIFO model pops a moment after the edge so the DUT samples the pre-pop head byte.
  always @(posedge clk) begin
    logic [3:0] r;
    logic       rs;
    r  = rden;
    rs = rst;
    #1;
    for (int p = 0; p < 4; p++) begin
      if (rs) begin
        fq[p].delete();
        in_frame[p] = 1'b0;
      end else if (r[p]) begin
        if (fq[p].size() == 0) begin
          spurious++;
        end else begin
          pops[p]++;
          if (!in_frame[p]) begin
            order.push_back(p);
            in_frame[p] = 1'b1;
          end
          if (fq[p][0][8]) in_frame[p] = 1'b0;
          void'(fq[p].pop_front());
        end
      end
    end
    refresh();
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int p, input int start, input int len);
    for (int k = 0; k < len; k++) fq[p].push_back({(k == len - 1), 8'(start + k)});
    refresh();
  endtask

  task automatic push_bytes(input int p, input int start, input int len, input logic last);
    for (int k = 0; k < len; k++) fq[p].push_back({(last && k == len - 1), 8'(start + k)});
    refresh();
  endtask

  task automatic apply_stimulus(input logic [3:0] we, input logic [31:0] di);
    @(negedge clk);
    bus.cfg_we = we;
    bus.cfg_di = di;
    @(negedge clk);
    bus.cfg_we = 4'b0000;
  endtask

  task automatic read_word(input int w, output logic [31:0] data);
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'(w) << 2;
    @(negedge clk);
    check_output("iomem_ready_hi", {31'b0, bus.iomem_ready}, 32'd1);
    data = bus.iomem_rdata;
    bus.iomem_valid = 1'b0;
    @(negedge clk);
    check_output("iomem_ready_lo", {31'b0, bus.iomem_ready}, 32'd0);
  endtask

  task automatic check_word(input string tag, input int w, input logic [31:0] exp);
    logic [31:0] d;
    read_word(w, d);
    check_output(tag, d, exp);
  endtask

  task automatic wait_frame_valid(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cfg_do[31]) break;
    end
    check_output(tag, {31'b0, bus.cfg_do[31]}, 32'd1);
  endtask

  task automatic wait_quiet(input string tag, input int p);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fq[p].size() == 0 && !bus.cfg_do[30]) break;
    end
    check_output(tag, {31'b0, bus.cfg_do[30]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    compared        = 0;
    mismatched      = 0;
    spurious        = 0;
    for (int p = 0; p < 4; p++) begin
      pops[p]     = 0;
      in_frame[p] = 1'b0;
    end
    refresh();
    rst             = 1'b1;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
    bus.iomem_addr  = '0;
    bus.cfg_we      = 4'b0000;
    bus.cfg_di      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_cfg_do", bus.cfg_do, 32'h0000_0000);
    check_output("rst_rdata", bus.iomem_rdata, 32'h0000_0000);
    check_output("rst_ready", {31'b0, bus.iomem_ready}, 32'd0);
    check_output("rst_rden", {28'b0, rden}, 32'd0);

    $display("[TB] 10 byte frame on p0");
    apply_stimulus(4'b1001, 32'h1000_0001);
    check_output("cfg_enable_mask", bus.cfg_do, 32'h1000_0001);
    push_frame(0, 8'h00, 10);
    wait_frame_valid("p0_fv_wait");
    check_output("p0_status", bus.cfg_do, 32'h910A_0001);
    check_output("p0_pops", 32'(pops[0]), 32'd10);
    check_word("p0_word0", 0, 32'h0001_0203);
    check_word("p0_word2", 2, 32'h0809_0000);
    apply_stimulus(4'b1000, 32'h9000_0000);
    check_output("w1c_status", bus.cfg_do, 32'h1000_0001);
    check_word("w1c_keeps_buf", 0, 32'h0001_0203);

    $display("[TB] 70 byte frame on p1, p3 parked while unmasked");
    apply_stimulus(4'b0001, 32'h0000_0002);
    push_frame(3, 8'hE0, 4);
    push_frame(1, 8'h40, 70);
    wait_frame_valid("p1_fv_wait");
    check_output("ovf_status", bus.cfg_do, 32'hB240_0002);
    check_output("ovf_pops", 32'(pops[1]), 32'd70);
    check_output("ovf_p1_empty", 32'(fq[1].size()), 32'd0);
    check_word("ovf_word0", 0, 32'h4041_4243);
    check_word("ovf_word15", 15, 32'h7C7D_7E7F);

    $display("[TB] three frames drained on p2 while buffer held");
    apply_stimulus(4'b0001, 32'h0000_0004);
    push_frame(2, 8'h90, 3);
    push_frame(2, 8'h98, 1);
    push_frame(2, 8'hA8, 5);
    wait_quiet("drain_quiet", 2);
    check_output("drain_status", bus.cfg_do, 32'hB240_0304);
    check_output("drain_pops", 32'(pops[2]), 32'd9);
    check_word("drain_buf_kept", 0, 32'h4041_4243);
    apply_stimulus(4'b1000, 32'h9000_0000);
    check_output("w1c_keeps_drop", bus.cfg_do, 32'h1000_0304);

    $display("[TB] p1 frame with an empty gap mid-frame");
    apply_stimulus(4'b0001, 32'h0000_0002);
    push_bytes(1, 8'hA0, 2, 1'b0);
    repeat (4) @(negedge clk);
    check_output("gap_busy", {31'b0, bus.cfg_do[30]}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check_output("gap_no_rden", {28'b0, rden}, 32'd0);
    end
    push_bytes(1, 8'hA2, 4, 1'b1);
    wait_frame_valid("gap_fv_wait");
    check_output("gap_status", bus.cfg_do, 32'h9206_0302);
    check_output("gap_spurious", 32'(spurious), 32'd0);
    check_word("gap_word0", 0, 32'hA0A1_A2A3);
    check_word("gap_word1", 1, 32'hA4A5_4647);
    apply_stimulus(4'b1000, 32'h9000_0000);

    $display("[TB] single byte frame");
    push_frame(1, 8'h5A, 1);
    wait_frame_valid("one_fv_wait");
    check_output("one_status", bus.cfg_do, 32'h9201_0302);
    check_word("one_word0", 0, 32'h5AA1_A2A3);
    apply_stimulus(4'b1000, 32'h9000_0000);

    $display("[TB] exactly 64 byte frame");
    push_frame(1, 8'h00, 64);
    wait_frame_valid("full_fv_wait");
    check_output("full_status", bus.cfg_do, 32'h9240_0302);
    check_word("full_word15", 15, 32'h3C3D_3E3F);
    apply_stimulus(4'b1000, 32'h9000_0000);
    check_output("p3_untouched", 32'(pops[3]), 32'd0);

    $display("[TB] reset in the middle of a capture");
    push_frame(1, 8'h20, 20);
    repeat (6) @(negedge clk);
    check_output("mid_busy", {31'b0, bus.cfg_do[30]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_cfg_do", bus.cfg_do, 32'h0000_0000);
    check_output("midrst_rden", {28'b0, rden}, 32'd0);
    check_output("midrst_rdata", bus.iomem_rdata, 32'h0000_0000);
    rst = 1'b0;
    @(negedge clk);
    check_word("midrst_buf_zero", 0, 32'h0000_0000);

    $display("[TB] round robin between p0 and p3");
    apply_stimulus(4'b1001, 32'h1000_000F);
    order.delete();
    push_frame(0, 8'h10, 2);
    push_frame(0, 8'h20, 2);
    push_frame(3, 8'h30, 2);
    push_frame(3, 8'h40, 2);
    wait_quiet("rr_quiet_p0", 0);
    wait_quiet("rr_quiet_p3", 3);
    check_output("rr_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      check_output("rr_grant0", 32'(order[0]), 32'd0);
      check_output("rr_grant1", 32'(order[1]), 32'd3);
      check_output("rr_grant2", 32'(order[2]), 32'd0);
      check_output("rr_grant3", 32'(order[3]), 32'd3);
    end
    check_output("rr_status", bus.cfg_do, 32'h9102_030F);
    check_word("rr_word0", 0, 32'h1011_0000);
    apply_stimulus(4'b1000, 32'h9000_0000);
    check_output("rr_w1c", bus.cfg_do, 32'h1000_030F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
